carry_chain_pipe: RTL and testbench

CARRY_CHAIN_PIPE -- requirements
Module: carry_chain_pipe

---
 rtl/carry_chain_pipe_if.sv | 27 ++
 rtl/carry_chain_pipe.sv | 98 +++++++++
 tb/tb_carry_chain_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/carry_chain_pipe_if.sv
// Operand/result handshake bundle for the segmented carry-chain adder pipeline.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface carry_chain_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/carry_chain_pipe.sv
// Add/subtract pipeline that resolves one SEG-bit carry segment per stage, skewing the
// operand bits still to be added and de-skewing finished sum bits so each beat leaves whole.
module carry_chain_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic               clk,
  input logic               rst_n,
  carry_chain_pipe_if.slave bus
);
  localparam int NSEG = WIDTH / SEG;

  logic             advance;
  logic [WIDTH-1:0] effB;

  // The whole pipe moves in lockstep, so only the output register's occupancy gates it.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction folds into addition here; later stages only ever see the effective operand.
  assign effB = bus.sub ? ~bus.b : bus.b;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * SEG;
    localparam int HI   = (k + 1) * SEG;

    logic            srcValid;
    logic            srcCarry;
    logic [IN_W-1:0] opA;
    logic [IN_W-1:0] opB;
    logic [SEG:0]    segRes;
    logic [HI-1:0]   sum_d;
    logic [HI-1:0]   sum_q;
    logic            valid_q;
    logic            carry_q;

    if (k == 0) begin : g_src
      assign srcValid = bus.in_valid;
      assign srcCarry = bus.sub ? 1'b1 : bus.cin;
      assign opA      = bus.a;
      assign opB      = effB;
      assign sum_d    = segRes[SEG-1:0];
    end else begin : g_src
      assign srcValid = g_stage[k-1].valid_q;
      assign srcCarry = g_stage[k-1].carry_q;
      assign opA      = g_stage[k-1].g_rem.aRem_q;
      assign opB      = g_stage[k-1].g_rem.bRem_q;
      assign sum_d    = {segRes[SEG-1:0], g_stage[k-1].sum_q};
    end

    assign segRes = {1'b0, opA[SEG-1:0]} + {1'b0, opB[SEG-1:0]} + {{SEG{1'b0}}, srcCarry};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= srcValid;
        carry_q <= segRes[SEG];
        sum_q   <= sum_d;
      end
    end

    // Operand bits above this segment ride along until their own stage consumes them.
    if (IN_W > SEG) begin : g_rem
      logic [IN_W-SEG-1:0] aRem_q;
      logic [IN_W-SEG-1:0] bRem_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          aRem_q <= '0;
          bRem_q <= '0;
        end else if (advance) begin
          aRem_q <= opA[IN_W-1:SEG];
          bRem_q <= opB[IN_W-1:SEG];
        end
      end
    end

    if (k == NSEG - 1) begin : g_out
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (opA[SEG-1] == opB[SEG-1]) && (segRes[SEG-1] != opA[SEG-1]);
        end
      end

      assign bus.out_valid = valid_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = carry_q;
      assign bus.ovf       = ovf_q;
    end
  end
endmodule

// File: tb/tb_carry_chain_pipe.sv
// Directed and random checks of carry_chain_pipe (WIDTH=16, SEG=4) against hand-computed
// results and a 17-bit reference sum, including stalls, bubbles and mid-flight reset.
module tb_carry_chain_pipe;
  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSEG  = WIDTH / SEG;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  carry_chain_pipe_if #(.WIDTH(WIDTH)) bus ();

  carry_chain_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checkCount = 0;
  int          failCount  = 0;
  int          stepCount  = 0;
  logic        checkLat   = 1'b0;
  logic [17:0] expQ[$];
  int          stampQ[$];

  // Expected results packed as {ovf, cout, sum}.
  logic [15:0] dA[9] = '{16'h0001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF,
                         16'h8000, 16'h0005, 16'h1234, 16'h8000};
  logic [15:0] dB[9] = '{16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'h0001,
                         16'h0001, 16'h0005, 16'h0234, 16'h8000};
  logic        dC[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        dS[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [17:0] dE[9] = '{18'h00004, 18'h28000, 18'h0FFFF, 18'h10000, 18'h10000,
                         18'h37FFF, 18'h10000, 18'h11000, 18'h30000};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [17:0] refModel(input logic [15:0] aIn, input logic [15:0] bIn,
                                           input logic cinIn, input logic subIn);
    logic [15:0] eb;
    logic [16:0] full;
    logic        ov;
    eb   = subIn ? ~bIn : bIn;
    full = {1'b0, aIn} + {1'b0, eb} + {16'd0, (subIn ? 1'b1 : cinIn)};
    ov   = (aIn[15] == eb[15]) && (full[15] != aIn[15]);
    return {ov, full};
  endfunction

  task automatic popAndCheck();
    logic [17:0] e;
    int          st;
    if (expQ.size() == 0) begin
      checkOutput("spurious_beat", 32'd1, 32'd0);
      return;
    end
    e  = expQ.pop_front();
    st = stampQ.pop_front();
    checkOutput("sum",  32'(bus.sum),  32'(e[15:0]));
    checkOutput("cout", 32'(bus.cout), 32'(e[16]));
    checkOutput("ovf",  32'(bus.ovf),  32'(e[17]));
    if (checkLat) checkOutput("latency", 32'(stepCount - st), 32'(NSEG));
  endtask

  // One clock step: drive at the falling edge, observe the handshake just after, clock at the rise.
  task automatic applyStimulus(input logic iv, input logic [15:0] aIn, input logic [15:0] bIn,
                               input logic cinIn, input logic subIn, input logic ordyIn,
                               input logic rstIn, input logic [17:0] expIn,
                               output logic accepted);
    @(negedge clk);
    rst_n         = rstIn;
    bus.in_valid  = iv;
    bus.a         = aIn;
    bus.b         = bIn;
    bus.cin       = cinIn;
    bus.sub       = subIn;
    bus.out_ready = ordyIn;
    #1;
    stepCount++;
    accepted = 1'b0;
    if (rstIn) begin
      if (bus.out_valid && bus.out_ready) begin
        popAndCheck();
      end else if (bus.out_valid && expQ.size() > 0) begin
        checkOutput("held_sum", 32'(bus.sum), 32'(expQ[0][15:0]));
      end
      if (iv && bus.in_ready) begin
        expQ.push_back(expIn);
        stampQ.push_back(stepCount);
        accepted = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic ordyIn);
    logic acc;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordyIn, 1'b1, 18'h0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expQ.size() > 0; i++) idle(1'b1);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic        acc;
    logic        ordy;
    logic        iv;
    int          idx;
    logic [15:0] rA;
    logic [15:0] rB;
    logic        rC;
    logic        rS;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, acc);
    applyStimulus(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, acc);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("reset_sum",       32'(bus.sum),       32'd0);
    checkOutput("reset_cout",      32'(bus.cout),      32'd0);
    checkOutput("reset_ovf",       32'(bus.ovf),       32'd0);

    $display("[TB] directed vectors");
    checkLat = 1'b1;
    applyStimulus(1'b1, dA[0], dB[0], dC[0], dS[0], 1'b1, 1'b1, dE[0], acc);
    checkOutput("accept_first", 32'(acc), 32'd1);
    for (int i = 1; i < NSEG; i++) begin
      idle(1'b1);
      checkOutput("early_out_valid", 32'(bus.out_valid), 32'd0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 1; i < 9; i++) begin
      applyStimulus(1'b1, dA[i], dB[i], dC[i], dS[i], 1'b1, 1'b1, dE[i], acc);
      checkOutput("accept_stream", 32'(acc), 32'd1);
    end
    drain();
    checkLat = 1'b0;

    $display("[TB] stall stream");
    idx = 0;
    for (int s = 1; s <= 60 && (idx < 8 || expQ.size() > 0); s++) begin
      ordy = !(s >= 6 && s <= 8);
      if (idx < 8) begin
        rA = 16'h1357 * 16'(idx + 1);
        rB = 16'hF0E1 ^ 16'(idx * 16'h0111);
        rC = idx[1];
        rS = idx[0];
        applyStimulus(1'b1, rA, rB, rC, rS, ordy, 1'b1, refModel(rA, rB, rC, rS), acc);
        if (acc) idx++;
      end else begin
        idle(ordy);
      end
      if (s >= 6 && s <= 8) begin
        checkOutput("stall_in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
    end
    checkOutput("stall_beats_sent", 32'(idx), 32'd8);
    drain();

    $display("[TB] reset with beats in flight");
    for (int i = 0; i < 3; i++) begin
      rA = 16'h1000 + 16'(i);
      applyStimulus(1'b1, rA, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, refModel(rA, 16'h0001, 1'b0, 1'b0), acc);
    end
    applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 18'h0, acc);
    expQ.delete();
    stampQ.delete();
    idle(1'b1);
    checkOutput("post_reset_sum",  32'(bus.sum),  32'd0);
    checkOutput("post_reset_cout", 32'(bus.cout), 32'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
      idle(1'b1);
    end

    $display("[TB] random add/sub");
    idx = 0;
    rA  = 16'($urandom);
    rB  = 16'($urandom);
    rC  = 1'($urandom);
    rS  = 1'($urandom);
    for (int s = 0; s < 400 && idx < 40; s++) begin
      ordy = ($urandom_range(0, 3) != 0);
      iv   = ($urandom_range(0, 4) != 0);
      applyStimulus(iv, rA, rB, rC, rS, ordy, 1'b1, refModel(rA, rB, rC, rS), acc);
      if (acc) begin
        idx++;
        rA = 16'($urandom);
        rB = 16'($urandom);
        rC = 1'($urandom);
        rS = 1'($urandom);
      end
    end
    checkOutput("random_beats_sent", 32'(idx), 32'd40);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
